// File: rtl/f_div_pkg.sv
// f_div_pkg: shared constants and state encoding for the sequential
// single-precision divider (f_div_seq) and its datapath step (f_div_step).
//   BIAS     - IEEE-754 single exponent bias
//   QBITS    - quotient bits produced, one per CALC cycle
//   MANT_W   - mantissa width including the implicit leading 1
//   EXP_W    - exponent width
//   REM_W    - partial remainder width
//   EXP_ALL1 - exponent pattern used for the divide-by-zero result
package f_div_pkg;

   localparam int BIAS   = 127;
   localparam int QBITS  = 25;
   localparam int MANT_W = 24;
   localparam int EXP_W  = 8;
   localparam int REM_W  = MANT_W + 2;

   localparam logic [EXP_W-1:0] EXP_ALL1 = 8'hFF;

   // FSM encoding
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t CALC = 2'd1;
   localparam state_t NORM = 2'd2;
   localparam state_t DONE = 2'd3;

endpackage

// File: rtl/f_div_step.sv
// f_div_step: one restoring-division step (combinational).
//   rem      in  REM_W   current partial remainder
//   dbit     in  1       next dividend bit to shift in
//   mb       in  MANT_W  divisor mantissa
//   rem_next out REM_W   partial remainder after this step
//   qbit     out 1       quotient bit produced by this step
module f_div_step
   import f_div_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic              dbit,
   input  logic [MANT_W-1:0] mb,
   output logic [REM_W-1:0]  rem_next,
   output logic              qbit
);

   logic [REM_W-1:0] shifted;
   logic [REM_W-1:0] divisor;
   logic [REM_W-1:0] diff;

   assign shifted  = {rem[REM_W-2:0], dbit};
   assign divisor  = {{(REM_W-MANT_W){1'b0}}, mb};
   assign diff     = shifted - divisor;
   assign qbit     = (shifted >= divisor);
   assign rem_next = qbit ? diff : shifted;

endmodule

// File: rtl/f_div_seq.sv
// f_div_seq: sequential single-precision divider, result = A / B.
// Implicit leading 1, truncation, no NaN/Inf/denormals, 8-bit modular
// exponent. Mantissa quotient comes from a restoring divider, one bit/clock.
//   clk         in  1   clock, rising edge
//   rst_n       in  1   asynchronous active-low reset
//   start       in  1   request a divide (sampled only in IDLE)
//   A, B        in  32  dividend / divisor, latched on accepted start
//   busy        out 1   cycle after accepted start through the done cycle
//   done        out 1   one-cycle pulse, result valid
//   result      out 32  quotient, held until the next done
//   div_by_zero out 1   divisor-was-zero flag for the current result
module f_div_seq
   import f_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        div_by_zero
);

   state_t             state;
   logic               sign;
   logic [EXP_W-1:0]   ea, eb;
   logic [MANT_W-1:0]  mb;
   logic               za, zb;
   logic [REM_W-1:0]   rem;
   logic [QBITS-1:0]   dvd;   // remaining dividend bits, MSB next
   logic [QBITS-1:0]   q;
   logic [4:0]         cnt;

   logic [REM_W-1:0]   rem_next;
   logic               qbit;

   f_div_step u_step (
      .rem      (rem),
      .dbit     (dvd[QBITS-1]),
      .mb       (mb),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   // Normalisation: q is in (2^23, 2^25), so the leading 1 is bit 24 or 23.
   logic [EXP_W-1:0]  exp_q;
   logic [22:0]       mant_q;

   always_comb begin
      exp_q  = ea - eb + EXP_W'(BIAS) - {{(EXP_W-1){1'b0}}, ~q[QBITS-1]};
      mant_q = q[QBITS-1] ? q[23:1] : q[22:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sign        <= 1'b0;
         ea          <= '0;
         eb          <= '0;
         mb          <= '0;
         za          <= 1'b0;
         zb          <= 1'b0;
         rem         <= '0;
         dvd         <= '0;
         q           <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sign <= A[31] ^ B[31];
                  ea   <= A[30:23];
                  eb   <= B[30:23];
                  mb   <= {1'b1, B[22:0]};
                  za   <= (A[30:0] == 31'h0);
                  zb   <= (B[30:0] == 31'h0);
                  // The dividend is {mA, 24'b0}. Its top 23 bits, mA[23:1],
                  // are always below mB, so the long-division steps for them
                  // would only emit zeros; they start out in the remainder and
                  // the remaining 25 bits are shifted in one per CALC cycle.
                  rem  <= {{(REM_W-MANT_W+1){1'b0}}, 1'b1, A[22:1]};
                  dvd  <= {A[0], {(QBITS-1){1'b0}}};
                  q    <= '0;
                  cnt  <= 5'(QBITS-1);
                  busy <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               rem <= rem_next;
               dvd <= {dvd[QBITS-2:0], 1'b0};
               q   <= {q[QBITS-2:0], qbit};
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0)
                  state <= NORM;
            end
            NORM: begin
               if (zb) begin
                  result      <= {sign, EXP_ALL1, 23'h0};
                  div_by_zero <= 1'b1;
               end else if (za) begin
                  result      <= 32'h0;
                  div_by_zero <= 1'b0;
               end else begin
                  result      <= {sign, exp_q, mant_q};
                  div_by_zero <= 1'b0;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            default: begin // DONE
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
